tile_lane_engine: RTL and testbench
===================================

# tile_lane_engine

Parametrised game-state engine for the Piano Tiles top level. It generalises the single per-frame moving object into NUM_LANES independent lanes, each holding up to DEPTH falling tiles in a circular buffer. The engine accepts spawn requests from the Nios II software through a valid/ready handshake and scores key presses decoded from the USB keycode against a hit window. It answers per-pixel occupancy queries from the colour mapper.

## Interface
- NUM_LANES, 4, number of tile lanes (2..8)
- DEPTH, 4, tiles buffered per lane (power of 2)
- Y_W, 10, tile Y coordinate width
- TILE_H, 60, tile height in pixels
- SCREEN_H, 480, Y at which a tile is off-screen
- HIT_Y, 400, first Y of hit window (head tile top Y)
- HIT_WIN, 80, hit window length
- MAX_MISS, 3, misses before game over
- Clk  in  1  50 MHz system clock; all logic on the rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; enters RUN and clears lanes, score and misses
- frame_tick  in  1  one-cycle pulse per video frame, synchronous to Clk
- speed  in  4  pixels advanced per frame_tick
- spawn_valid  in  1  spawn request
- spawn_lane  in  $clog2(NUM_LANES)  target lane
- spawn_ready  out  1  engine can accept a spawn this cycle
- key_valid  in  1  one-cycle key press pulse
- key_lane  in  $clog2(NUM_LANES)  lane pressed
- query_y  in  Y_W  renderer DrawY
- tile_on  out  NUM_LANES  lane occupancy at query_y; 1-cycle latency
- hit  out  1  registered pulse, correct press
- miss  out  1  registered pulse, wrong press or escaped tile
- score  out  16  saturating hit count
- miss_cnt  out  2  misses, saturating at MAX_MISS
- state  out  2  IDLE=0, RUN=1, OVER=2

## Operation
- Reset values: state IDLE; all lanes empty; score 0; miss_cnt 0; hit, miss, tile_on 0; spawn_ready 0.
- IDLE: everything is ignored except start. start moves the engine to RUN.
- RUN behaviour per cycle, evaluated in this order against pre-cycle state:
  - Key press: if lane key_lane is non-empty and its head (oldest) tile Y is within [HIT_Y, HIT_Y+HIT_WIN), the head is popped, hit is asserted and score is incremented (saturating at 0xFFFF). Otherwise miss is asserted and nothing is popped.
  - frame_tick: every valid tile's Y increases by speed. The addition is done at Y_W+1 bits. Any lane whose advanced head is ≥ SCREEN_H pops that head. Each such lane adds one to the miss count.
  - Spawn: a spawn is accepted when spawn_valid and spawn_ready are both high. The new tile is pushed at Y=0 into spawn_lane.
- spawn_ready = (state==RUN) and spawn_lane not full. Fullness is based on the pre-cycle count, so a same-cycle pop does not free a slot.
- The same lane can be popped by a key press and receive a push in the same cycle. If a key pops a lane's head in the cycle of a frame_tick, the advance applies to the remaining tiles.
- miss_cnt adds all miss sources in the cycle (key miss plus escaped lanes) and saturates. miss pulses once per cycle.
- When miss_cnt reaches MAX_MISS, state goes to OVER on the next edge. In OVER, frame_tick, key_valid and spawn are ignored and positions freeze. start returns the engine to RUN with everything cleared.
- start during RUN re-initialises immediately.
- tile_on[l] = 1 if any valid tile in lane l has Y ≤ query_y < Y+TILE_H. The comparison is done at Y_W+1 bits.

## Timing
- hit, miss and score update 1 cycle after key_valid.
- Tile positions update on the edge that samples frame_tick.
- tile_on is registered, 1 cycle after query_y.
- Spawn handshake completes in the same cycle; the new tile is visible to tile_on 2 cycles later.
- Reset asserted mid-frame clears state asynchronously. No pulse is emitted on reset release.

## Configuration
- TILE_ENGINE_SPEEDUP_EN defined: effective speed = speed + score[15:5], saturating at 15.
- Not defined: effective speed = speed.

## Structure
- Package tile_pkg holds:
  - the state_t enum (IDLE, RUN, OVER)
  - the LANE_W localparam helper
  - default geometry constants
- Sub-module tile_lane: one per lane, instantiated with generate. It contains the DEPTH-entry circular buffer (head/tail pointers, count), advance logic, head hit-window and off-screen flags, and the occupancy compare.
- The top contains the FSM, score and miss counters, spawn and key steering, and the tile_on register.

## Test plan
- Reset, then start; spawn lane 2, then 7 frame_ticks at speed 8 → head Y=56; tile_on[2]=1 for query_y 56, 0 for query_y 116.
- Advance a lane-1 tile to Y=400 and press key lane 1 → hit pulse, score=1, lane empty. A press at Y=399 → miss, tile kept.
- 4 spawns into lane 0 with DEPTH=4 → spawn_ready=0; a 5th spawn_valid is not accepted; after a hit pop → spawn_ready=1.
- Tiles in lanes 0 and 3 both reach Y ≥ 480 on the same frame_tick → one miss pulse, miss_cnt=2. A wrong key afterwards → miss_cnt=3, OVER; further frame_ticks leave positions unchanged.
- Key hit and frame_tick in the same cycle, lane with 2 tiles at Y 410 and 100, speed 4 → head popped, remaining tile Y=104.
- With TILE_ENGINE_SPEEDUP_EN, score=64 and speed=4 → advance of 6 per frame.

Source files
------------

// File: rtl/tile_lane_engine_pkg.sv
// tile_pkg: shared state encoding, lane-index width helper and default
// playfield geometry for the tile lane engine.
package tile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int DEF_NUM_LANES = 4;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_Y_W       = 10;
  localparam int DEF_TILE_H    = 60;
  localparam int DEF_SCREEN_H  = 480;
  localparam int DEF_HIT_Y     = 400;
  localparam int DEF_HIT_WIN   = 80;
  localparam int DEF_MAX_MISS  = 3;

  // Width of a lane index; never zero so single-lane builds still elaborate.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LANE_W = lane_w(DEF_NUM_LANES);

endpackage

// File: rtl/tile_lane_engine_if.sv
// tile_lane_engine_if: game control, spawn/key handshakes, renderer query
// and status outputs of the tile lane engine. The software/renderer side is
// the master, the engine is the slave.
interface tile_lane_engine_if #(
  parameter int NUM_LANES = 4,
  parameter int Y_W       = 10
);
  localparam int LW = tile_pkg::lane_w(NUM_LANES);

  logic                 start;
  logic                 frame_tick;
  logic [3:0]           speed;
  logic                 spawn_valid;
  logic [LW-1:0]        spawn_lane;
  logic                 spawn_ready;
  logic                 key_valid;
  logic [LW-1:0]        key_lane;
  logic [Y_W-1:0]       query_y;
  logic [NUM_LANES-1:0] tile_on;
  logic                 hit;
  logic                 miss;
  logic [15:0]          score;
  logic [1:0]           miss_cnt;
  logic [1:0]           state;

  modport master (
    output start, frame_tick, speed, spawn_valid, spawn_lane,
           key_valid, key_lane, query_y,
    input  spawn_ready, tile_on, hit, miss, score, miss_cnt, state
  );

  modport slave (
    input  start, frame_tick, speed, spawn_valid, spawn_lane,
           key_valid, key_lane, query_y,
    output spawn_ready, tile_on, hit, miss, score, miss_cnt, state
  );

endinterface

// File: rtl/tile_lane_engine_lane.sv
// tile_lane: one lane of falling tiles. Circular buffer of tile Y positions
// (oldest at head), per-frame advance, head hit-window / off-screen flags
// and the combinational occupancy compare against the renderer's query_y.
module tile_lane
  import tile_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int Y_W      = DEF_Y_W,
  parameter int TILE_H   = DEF_TILE_H,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int HIT_Y    = DEF_HIT_Y,
  parameter int HIT_WIN  = DEF_HIT_WIN
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           pop_key,
  input  logic           advance,
  input  logic [3:0]     adv,
  input  logic           push,
  input  logic [Y_W-1:0] query_y,
  output logic           full,
  output logic           head_win,
  output logic           esc,
  output logic           occ
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [Y_W-1:0] y_q [DEPTH];
  logic [PW-1:0]  head_q, tail_q;
  logic [PW:0]    cnt_q;
  logic [Y_W:0]   head_y, head_adv;
  logic [PW-1:0]  off;
  logic           empty, pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (PW+1)'(DEPTH));
  assign head_y   = {1'b0, y_q[head_q]};
  assign head_adv = head_y + (Y_W+1)'(adv);
  assign head_win = !empty && (head_y >= (Y_W+1)'(HIT_Y))
                           && (head_y <  (Y_W+1)'(HIT_Y + HIT_WIN));
  // A head already taken by a key press this cycle cannot also escape.
  assign esc      = advance && !empty && !pop_key
                    && (head_adv >= (Y_W+1)'(SCREEN_H));
  assign pop      = pop_key || esc;

  // Occupancy: any live entry whose span [Y, Y+TILE_H) covers query_y.
  always_comb begin
    occ = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      if (({1'b0, off} < cnt_q) &&
          ({1'b0, y_q[i]} <= {1'b0, query_y}) &&
          ({1'b0, query_y} < ({1'b0, y_q[i]} + (Y_W+1)'(TILE_H))))
        occ = 1'b1;
    end
  end

  // Buffer update: advance every slot, then pop head / push a fresh tile at Y=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) y_q[i] <= '0;
    end else if (clr) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (advance)
        for (int i = 0; i < DEPTH; i++) y_q[i] <= y_q[i] + Y_W'(adv);
      if (pop) head_q <= head_q + 1'b1;
      if (push) begin
        y_q[tail_q] <= '0;
        tail_q      <= tail_q + 1'b1;
      end
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

endmodule

// File: rtl/tile_lane_engine.sv
// tile_lane_engine: game FSM, score / miss accounting, spawn and key steering
// into NUM_LANES tile_lane instances, and the registered tile_on output.
// Optional build macro TILE_ENGINE_SPEEDUP_EN: fall speed grows with score.
module tile_lane_engine
  import tile_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int Y_W       = DEF_Y_W,
  parameter int TILE_H    = DEF_TILE_H,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int HIT_Y     = DEF_HIT_Y,
  parameter int HIT_WIN   = DEF_HIT_WIN,
  parameter int MAX_MISS  = DEF_MAX_MISS
) (
  input logic               Clk,
  input logic               Reset,
  tile_lane_engine_if.slave bus
);
  localparam int LW = lane_w(NUM_LANES);

  state_t               state_q;
  logic [15:0]          score_q;
  logic [1:0]           miss_q;
  logic                 hit_q, miss_pulse_q;
  logic [NUM_LANES-1:0] tile_on_q;
  logic [NUM_LANES-1:0] full, head_win, esc, occ, pop_key, push;
  logic                 run, tick_run, key_hit, key_miss;
  logic [3:0]           eff_speed, esc_n;
  logic [4:0]           miss_sum;
  logic [1:0]           miss_next;

  // start wins over any play activity in the same cycle.
  assign run      = (state_q == RUN) && !bus.start;
  assign tick_run = run && bus.frame_tick;
  assign key_hit  = run && bus.key_valid && head_win[bus.key_lane];
  assign key_miss = run && bus.key_valid && !head_win[bus.key_lane];

  assign bus.spawn_ready = (state_q == RUN) && !full[bus.spawn_lane];

`ifdef TILE_ENGINE_SPEEDUP_EN
  logic [11:0] speed_sum;
  assign speed_sum = 12'(bus.speed) + 12'(score_q[15:5]);
  assign eff_speed = (speed_sum > 12'd15) ? 4'd15 : speed_sum[3:0];
`else
  assign eff_speed = bus.speed;
`endif

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign pop_key[l] = key_hit && (bus.key_lane == LW'(l));
    assign push[l]    = run && bus.spawn_valid && bus.spawn_ready
                        && (bus.spawn_lane == LW'(l));
    tile_lane #(
      .DEPTH(DEPTH), .Y_W(Y_W), .TILE_H(TILE_H), .SCREEN_H(SCREEN_H),
      .HIT_Y(HIT_Y), .HIT_WIN(HIT_WIN)
    ) u_lane (
      .clk(Clk), .rst(Reset), .clr(bus.start), .pop_key(pop_key[l]),
      .advance(tick_run), .adv(eff_speed), .push(push[l]),
      .query_y(bus.query_y), .full(full[l]), .head_win(head_win[l]),
      .esc(esc[l]), .occ(occ[l])
    );
  end

  // Count escaped lanes so several escapes on one frame all add to miss_cnt.
  always_comb begin
    esc_n = '0;
    for (int l = 0; l < NUM_LANES; l++) esc_n = esc_n + 4'(esc[l]);
  end

  assign miss_sum  = 5'(miss_q) + 5'(esc_n) + 5'(key_miss);
  assign miss_next = (miss_sum >= 5'(MAX_MISS)) ? 2'(MAX_MISS) : miss_sum[1:0];

  // Game FSM with score, miss counter and registered hit/miss pulses.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      score_q      <= '0;
      miss_q       <= '0;
      hit_q        <= 1'b0;
      miss_pulse_q <= 1'b0;
    end else begin
      hit_q        <= 1'b0;
      miss_pulse_q <= 1'b0;
      if (bus.start) begin
        state_q <= RUN;
        score_q <= '0;
        miss_q  <= '0;
      end else if (state_q == RUN) begin
        hit_q        <= key_hit;
        miss_pulse_q <= key_miss || (esc != '0);
        if (key_hit && (score_q != 16'hFFFF)) score_q <= score_q + 16'd1;
        miss_q <= miss_next;
        if (miss_sum >= 5'(MAX_MISS)) state_q <= OVER;
      end
    end
  end

  // Occupancy register: one-cycle latency from query_y to tile_on.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) tile_on_q <= '0;
    else       tile_on_q <= occ;
  end

  assign bus.tile_on  = tile_on_q;
  assign bus.hit      = hit_q;
  assign bus.miss     = miss_pulse_q;
  assign bus.score    = score_q;
  assign bus.miss_cnt = miss_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_tile_lane_engine.sv
// tb_tile_lane_engine: scoreboard bench. Each applied cycle pushes the
// behavioural model's expected outputs and the DUT's observed outputs;
// each scenario task drains and compares them.
module tb_tile_lane_engine;
  import tile_pkg::*;

  typedef struct packed {
    logic [3:0]  tile_on;
    logic        hit;
    logic        miss;
    logic [15:0] score;
    logic [1:0]  mc;
    logic [1:0]  st;
    logic        rdy;
  } out_t;

  logic Clk;
  logic Reset;
  tile_lane_engine_if bus ();

  tile_lane_engine dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int   n_vec = 0;
  int   n_err = 0;
  out_t exp_q[$];
  out_t obs_q[$];

  int my [4][$];
  int mscore, mmc, mst;

  function automatic int eff_spd(input int spd, input int sc);
`ifdef TILE_ENGINE_SPEEDUP_EN
    return (spd + (sc >> 5) > 15) ? 15 : spd + (sc >> 5);
`else
    if (sc < 0) return 0;
    return spd;
`endif
  endfunction

  function automatic void model_clear();
    for (int l = 0; l < 4; l++) my[l].delete();
    mscore = 0;
    mmc    = 0;
  endfunction

  // One clock of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic apply(input bit st, input bit kv, input int kl, input bit ft,
                       input int spd, input bit sv, input int sl, input int qy);
    out_t e, o;
    int   nm, ee, ps;
    bit   kpop;
    bus.start = st; bus.key_valid = kv; bus.key_lane = 2'(kl);
    bus.frame_tick = ft; bus.speed = 4'(spd);
    bus.spawn_valid = sv; bus.spawn_lane = 2'(sl); bus.query_y = 10'(qy);
    #4;
    o = '0;
    o.rdy = bus.spawn_ready;
    e = '0;
    for (int l = 0; l < 4; l++)
      for (int i = 0; i < my[l].size(); i++)
        if (my[l][i] <= qy && qy < my[l][i] + 60) e.tile_on[l] = 1'b1;
    e.rdy = (mst == 1) && (my[sl].size() < 4);
    ps = mscore;
    if (st) begin
      model_clear();
      mst = 1;
    end else if (mst == 1) begin
      nm = 0; kpop = 0;
      if (kv) begin
        if (my[kl].size() > 0 && my[kl][0] >= 400 && my[kl][0] < 480) begin
          void'(my[kl].pop_front());
          kpop = 1; e.hit = 1'b1;
          if (mscore < 65535) mscore++;
        end else nm++;
      end
      if (ft) begin
        ee = eff_spd(spd, ps);
        for (int l = 0; l < 4; l++) begin
          for (int i = 0; i < my[l].size(); i++) my[l][i] += ee;
          if (!(kpop && kl == l) && my[l].size() > 0 && my[l][0] >= 480) begin
            void'(my[l].pop_front());
            nm++;
          end
        end
      end
      if (sv && e.rdy) my[sl].push_back(0);
      e.miss = (nm > 0);
      mmc = (mmc + nm > 3) ? 3 : mmc + nm;
      if (mmc >= 3) mst = 2;
    end
    e.score = 16'(mscore); e.mc = 2'(mmc); e.st = 2'(mst);
    @(posedge Clk); #1;
    bus.start = 0; bus.key_valid = 0; bus.frame_tick = 0; bus.spawn_valid = 0;
    o.tile_on = bus.tile_on; o.hit = bus.hit; o.miss = bus.miss;
    o.score = bus.score; o.mc = bus.miss_cnt; o.st = bus.state;
    exp_q.push_back(e);
    obs_q.push_back(o);
  endtask

  task automatic start_game();         apply(1, 0, 0, 0, 0, 0, 0, 0);  endtask
  task automatic spawn(input int l);   apply(0, 0, 0, 0, 0, 1, l, 0);  endtask
  task automatic key(input int l);     apply(0, 1, l, 0, 0, 0, 0, 0);  endtask
  task automatic tick(input int s);    apply(0, 0, 0, 1, s, 0, 0, 0);  endtask
  task automatic query(input int y);   apply(0, 0, 0, 0, 0, 0, 0, y);  endtask

  task automatic test_reset();
    out_t o;
    bus.start = 0; bus.frame_tick = 0; bus.speed = 0; bus.spawn_valid = 0;
    bus.spawn_lane = 0; bus.key_valid = 0; bus.key_lane = 0; bus.query_y = 0;
    Reset = 0;
    #1 Reset = 1;
    repeat (2) @(posedge Clk);
    #1;
    o = {bus.tile_on, bus.hit, bus.miss, bus.score, bus.miss_cnt, bus.state, bus.spawn_ready};
    n_vec++;
    if (o !== '0) begin
      n_err++;
      $display("FAIL reset_values: got %h expected 0", o);
    end
    Reset = 0;
    mst = 0;
    model_clear();
    apply(0, 1, 1, 1, 8, 1, 2, 0);
    apply(0, 0, 0, 0, 0, 0, 2, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      out_t e, ob;
      e = exp_q.pop_front(); ob = obs_q.pop_front(); n_vec++;
      if (ob !== e) begin
        n_err++;
        $display("FAIL idle_ignore #%0d: got %h expected %h", i, ob, e);
      end
    end
  endtask

  task automatic test_spawn_advance();
    start_game();
    spawn(2);
    repeat (7) tick(8);
    query(56);
    query(116);
    query(115);
    query(55);
    for (int i = 0; exp_q.size() > 0; i++) begin
      out_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL spawn_advance #%0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_hit_window();
    start_game();
    spawn(1);
    repeat (26) tick(15);
    tick(9);
    key(1);
    tick(1);
    key(1);
    query(420);
    query(0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      out_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL hit_window #%0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_full();
    start_game();
    repeat (4) spawn(0);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    spawn(0);
    apply(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (26) tick(15);
    tick(10);
    query(0);
    apply(0, 1, 0, 0, 0, 1, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 400);
    apply(0, 1, 0, 0, 0, 1, 0, 0);
    query(0);
    query(400);
    for (int i = 0; exp_q.size() > 0; i++) begin
      out_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL full_lane #%0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_escape_over();
    start_game();
    spawn(0);
    spawn(3);
    repeat (31) tick(15);
    tick(15);
    query(0);
    spawn(2);
    repeat (3) tick(10);
    key(1);
    repeat (2) tick(10);
    query(30);
    query(89);
    query(90);
    spawn(2);
    key(2);
    for (int i = 0; exp_q.size() > 0; i++) begin
      out_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL escape_over #%0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_key_and_tick();
    start_game();
    spawn(1);
    repeat (20) tick(15);
    tick(10);
    spawn(1);
    repeat (10) tick(10);
    query(410);
    apply(0, 1, 1, 1, 4, 0, 0, 0);
    query(104);
    query(103);
    query(163);
    query(164);
    query(414);
    for (int i = 0; exp_q.size() > 0; i++) begin
      out_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL key_and_tick #%0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    start_game();
    query(104);
    for (int l = 0; l < 4; l++) spawn(l);
    query(0);
    query(59);
    query(60);
    apply(0, 0, 0, 1, 5, 1, 0, 0);
    query(4);
    query(64);
    for (int i = 0; exp_q.size() > 0; i++) begin
      out_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL back_to_back #%0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_t o;
    key(2);
    tick(3);
    query(8);
    #2 Reset = 1;
    #1;
    o = {bus.tile_on, bus.hit, bus.miss, bus.score, bus.miss_cnt, bus.state, bus.spawn_ready};
    n_vec++;
    if (o !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got %h expected 0", o);
    end
    @(posedge Clk); #1;
    Reset = 0;
    mst = 0;
    model_clear();
    query(0);
    apply(0, 1, 0, 1, 4, 1, 0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      out_t e, ob;
      e = exp_q.pop_front(); ob = obs_q.pop_front(); n_vec++;
      if (ob !== e) begin
        n_err++;
        $display("FAIL reset_mid_seq #%0d: got %h expected %h", i, ob, e);
      end
    end
  endtask

`ifdef TILE_ENGINE_SPEEDUP_EN
  task automatic test_speedup();
    start_game();
    for (int r = 0; r < 16; r++) begin
      repeat (4) spawn(0);
      for (int t = 0; t < 40 && my[0][0] < 400; t++) tick(15);
      repeat (4) key(0);
    end
    spawn(3);
    tick(4);
    query(6);
    query(5);
    for (int i = 0; exp_q.size() > 0; i++) begin
      out_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL speedup #%0d: got %h expected %h", i, o, e);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_spawn_advance();
    test_hit_window();
    test_full();
    test_escape_over();
    test_key_and_tick();
    test_back_to_back();
    test_reset_mid();
`ifdef TILE_ENGINE_SPEEDUP_EN
    test_speedup();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
